// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding selects, stall generation and a single-entry multdiv scoreboard.
// Selects and stall are combinational; multdiv state updates one edge after acceptance. Define HAZARD_DECODE_FWD_EN to enable decode-stage forwarding.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int MD_LAT = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NSRC*REG_AW-1:0] fd_src,
    input  logic [NSRC*REG_AW-1:0] dx_src,
    input  logic [REG_AW-1:0]      dx_rd,
    input  logic                   dx_we,
    input  logic                   dx_is_load,
    input  logic                   dx_is_md,
    input  logic [REG_AW-1:0]      xm_rd,
    input  logic                   xm_we,
    input  logic                   xm_is_load,
    input  logic [REG_AW-1:0]      mw_rd,
    input  logic                   mw_we,
    output logic [2*NSRC-1:0]      fwd_sel,
    output logic [2*NSRC-1:0]      fd_fwd_sel,
    output logic                   stall,
    output logic                   md_busy,
    output logic [REG_AW-1:0]      md_rd,
    output logic                   md_done,
    output logic [15:0]            stall_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic [7:0] CNT_LOAD = 8'(MD_LAT - 1);

    logic [0:0]        state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic [REG_AW-1:0] md_rd_q, md_rd_d;
    logic              md_done_q, md_done_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [REG_AW-1:0] src_x, src_d;
    logic              dx_hit, late_hit, sb_hit;
    logic              load_use, branch_use, struct_hz, accept;

    function automatic logic is_prod(input logic we, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
        return we && (rd == src) && (src != '0);
    endfunction

    always_comb begin
        fwd_sel    = '0;
        fd_fwd_sel = '0;
        dx_hit     = 1'b0;
        late_hit   = 1'b0;
        sb_hit     = 1'b0;
        src_x      = '0;
        src_d      = '0;
        for (int k = 0; k < NSRC; k++) begin
            src_x = dx_src[k*REG_AW +: REG_AW];
            src_d = fd_src[k*REG_AW +: REG_AW];
            // A load in XM has no data yet, so it falls through to MW or the regfile.
            if (is_prod(xm_we, xm_rd, src_x) && !xm_is_load)
                fwd_sel[2*k +: 2] = 2'b01;
            else if (is_prod(mw_we, mw_rd, src_x))
                fwd_sel[2*k +: 2] = 2'b10;
            if (is_prod(dx_we, dx_rd, src_d))
                dx_hit = 1'b1;
            if (state_q == ST_BUSY && md_rd_q != '0 && md_rd_q == src_d)
                sb_hit = 1'b1;
`ifdef HAZARD_DECODE_FWD_EN
            if (is_prod(xm_we, xm_rd, src_d) && !xm_is_load)
                fd_fwd_sel[2*k +: 2] = 2'b01;
            else if (is_prod(mw_we, mw_rd, src_d))
                fd_fwd_sel[2*k +: 2] = 2'b10;
`else
            if (is_prod(xm_we, xm_rd, src_d) || is_prod(mw_we, mw_rd, src_d))
                late_hit = 1'b1;
`endif
        end
    end

    assign load_use   = dx_hit && dx_is_load;
    assign branch_use = dx_hit && !dx_is_load;
    assign struct_hz  = (state_q == ST_BUSY) && dx_is_md;
    // Only the D/X comparison terms survive while reset is held.
    assign stall      = load_use || branch_use || (reset && (sb_hit || struct_hz || late_hit));
    assign accept     = dx_is_md && (state_q == ST_IDLE) && !stall;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        md_rd_d   = md_rd_q;
        md_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    count_d = CNT_LOAD;
                    md_rd_d = dx_we ? dx_rd : '0;
                end
            end
            default: begin
                if (count_q == 8'd0) begin
                    state_d   = ST_IDLE;
                    md_done_d = 1'b1;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
        endcase
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            md_rd_q     <= '0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            md_rd_q     <= md_rd_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy   = (state_q == ST_BUSY);
    assign md_rd     = md_rd_q;
    assign md_done   = md_done_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard in its default build, MD_LAT=4.
module tb_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  fd_src, dx_src;
    logic [4:0]  dx_rd, xm_rd, mw_rd, md_rd;
    logic        dx_we, dx_is_load, dx_is_md, xm_we, xm_is_load, mw_we;
    logic [3:0]  fwd_sel, fd_fwd_sel;
    logic        stall, md_busy, md_done;
    logic [15:0] stall_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    hazard_scoreboard #(.REG_AW(5), .NSRC(2), .MD_LAT(4)) dut (
        .clock(clock), .reset(reset),
        .fd_src(fd_src), .dx_src(dx_src),
        .dx_rd(dx_rd), .dx_we(dx_we), .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
        .xm_rd(xm_rd), .xm_we(xm_we), .xm_is_load(xm_is_load),
        .mw_rd(mw_rd), .mw_we(mw_we),
        .fwd_sel(fwd_sel), .fd_fwd_sel(fd_fwd_sel), .stall(stall),
        .md_busy(md_busy), .md_rd(md_rd), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        fd_src = '0; dx_src = '0;
        dx_rd = '0; dx_we = 1'b0; dx_is_load = 1'b0; dx_is_md = 1'b0;
        xm_rd = '0; xm_we = 1'b0; xm_is_load = 1'b0;
        mw_rd = '0; mw_we = 1'b0;
    endtask

    task automatic apply_reset();
        set_idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        #2;
        tests_run++;
        if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        tests_run++;
        if (md_done !== 1'b0) begin tests_failed++; $display("FAIL reset_md_done: got %b want 0", md_done); end
        tests_run++;
        if (md_rd !== 5'd0) begin tests_failed++; $display("FAIL reset_md_rd: got %0d want 0", md_rd); end
        tests_run++;
        if (stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt); end
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
        // load-use still asserts stall while reset is held
        dx_is_load = 1'b1; dx_we = 1'b1; dx_rd = 5'd6; fd_src = {5'd0, 5'd6};
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL reset_load_use_stall: got %b want 1", stall); end
        apply_reset();
    endtask

    task automatic test_forwarding();
        apply_reset();
        dx_src = {5'd0, 5'd3};
        xm_rd = 5'd3; xm_we = 1'b1; mw_rd = 5'd3; mw_we = 1'b1;
        #1;
        tests_run++;
        if (fwd_sel !== 4'b0001) begin tests_failed++; $display("FAIL fwd_xm_priority: got %b want 0001", fwd_sel); end
        xm_we = 1'b0;
        #1;
        tests_run++;
        if (fwd_sel !== 4'b0010) begin tests_failed++; $display("FAIL fwd_mw: got %b want 0010", fwd_sel); end
        xm_we = 1'b1; xm_is_load = 1'b1;
        #1;
        tests_run++;
        if (fwd_sel !== 4'b0010) begin tests_failed++; $display("FAIL fwd_xm_load_skip: got %b want 0010", fwd_sel); end
        xm_is_load = 1'b0; dx_src = {5'd9, 5'd3}; mw_rd = 5'd9;
        #1;
        tests_run++;
        if (fwd_sel !== 4'b1001) begin tests_failed++; $display("FAIL fwd_two_operands: got %b want 1001", fwd_sel); end
        tests_run++;
        if (fd_fwd_sel !== 4'b0000) begin tests_failed++; $display("FAIL fd_fwd_tied: got %b want 0000", fd_fwd_sel); end
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL fwd_no_stall: got %b want 0", stall); end
    endtask

    task automatic test_load_use();
        apply_reset();
        dx_is_load = 1'b1; dx_rd = 5'd5; dx_we = 1'b1; fd_src = {5'd5, 5'd0};
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL load_use_stall: got %b want 1", stall); end
        tick();
        set_idle();
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL load_use_release: got %b want 0", stall); end
        tests_run++;
        if (stall_cnt !== 16'd1) begin tests_failed++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
        dx_rd = 5'd5; dx_we = 1'b1; fd_src = {5'd0, 5'd5};
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL branch_use_stall: got %b want 1", stall); end
        set_idle();
        xm_rd = 5'd4; xm_we = 1'b1; fd_src = {5'd0, 5'd4};
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL decode_xm_stall: got %b want 1", stall); end
        set_idle();
        mw_rd = 5'd12; mw_we = 1'b1; fd_src = {5'd12, 5'd0};
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL decode_mw_stall: got %b want 1", stall); end
        set_idle();
    endtask

    task automatic test_multdiv();
        apply_reset();
        dx_is_md = 1'b1; dx_we = 1'b1; dx_rd = 5'd7;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL md_start_stall: got %b want 0", stall); end
        tick();
        set_idle();
        fd_src = {5'd0, 5'd7};
        for (int c = 0; c < 4; c++) begin
            #1;
            tests_run++;
            if ({md_busy, stall, md_done, md_rd} !== {3'b110, 5'd7}) begin
                tests_failed++;
                $display("FAIL md_busy_cycle%0d: busy/stall/done/rd got %b%b%b/%0d want 110/7", c, md_busy, stall, md_done, md_rd);
            end
            tick();
        end
        #1;
        tests_run++;
        if ({md_busy, md_done, stall} !== 3'b010) begin tests_failed++; $display("FAIL md_done_pulse: busy/done/stall got %b%b%b want 010", md_busy, md_done, stall); end
        tests_run++;
        if (md_rd !== 5'd7) begin tests_failed++; $display("FAIL md_rd_hold: got %0d want 7", md_rd); end
        tests_run++;
        if (stall_cnt !== 16'd4) begin tests_failed++; $display("FAIL md_stall_cnt: got %0d want 4", stall_cnt); end
        tick();
        tests_run++;
        if (md_done !== 1'b0) begin tests_failed++; $display("FAIL md_done_single: got %b want 0", md_done); end
        set_idle();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        dx_is_md = 1'b1; dx_we = 1'b1; dx_rd = 5'd7;
        tick();
        dx_rd = 5'd8;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests_run++;
            if ({md_busy, stall} !== 2'b11) begin tests_failed++; $display("FAIL b2b_struct_cycle%0d: busy/stall got %b%b want 11", c, md_busy, stall); end
            tick();
        end
        tests_run++;
        if ({md_busy, stall, md_done} !== 3'b001) begin tests_failed++; $display("FAIL b2b_idle: busy/stall/done got %b%b%b want 001", md_busy, stall, md_done); end
        tick();
        dx_is_md = 1'b0;
        #1;
        tests_run++;
        if ({md_busy, md_rd} !== {1'b1, 5'd8}) begin tests_failed++; $display("FAIL b2b_reaccept: busy/rd got %b/%0d want 1/8", md_busy, md_rd); end
        for (int c = 0; c < 4; c++) tick();
        tests_run++;
        if ({md_busy, md_done} !== 2'b01) begin tests_failed++; $display("FAIL b2b_second_done: busy/done got %b%b want 01", md_busy, md_done); end
        set_idle();
    endtask

    task automatic test_reset_mid();
        int seen_done;
        apply_reset();
        dx_is_md = 1'b1; dx_we = 1'b1; dx_rd = 5'd7;
        tick();
        set_idle();
        fd_src = {5'd0, 5'd7};
        tick();
        tests_run++;
        if ({md_busy, stall_cnt} !== {1'b1, 16'd1}) begin tests_failed++; $display("FAIL midrst_pre: busy/cnt got %b/%0d want 1/1", md_busy, stall_cnt); end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({md_busy, stall_cnt, md_rd} !== {1'b0, 16'd0, 5'd0}) begin
            tests_failed++;
            $display("FAIL midrst_clear: busy/cnt/rd got %b/%0d/%0d want 0/0/0", md_busy, stall_cnt, md_rd);
        end
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL midrst_stall: got %b want 0", stall); end
        tick();
        reset = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (md_done !== 1'b0) seen_done++;
        end
        tests_run++;
        if (seen_done !== 0) begin tests_failed++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen_done); end
        set_idle();
    endtask

    task automatic test_zero_reg();
        apply_reset();
        dx_rd = 5'd0; dx_we = 1'b1; dx_is_load = 1'b1;
        xm_rd = 5'd0; xm_we = 1'b1; mw_rd = 5'd0; mw_we = 1'b1;
        #1;
        tests_run++;
        if ({fwd_sel, fd_fwd_sel, stall} !== 9'd0) begin
            tests_failed++;
            $display("FAIL zero_reg: fwd/fdfwd/stall got %b/%b/%b want 0000/0000/0", fwd_sel, fd_fwd_sel, stall);
        end
        dx_src = {5'd2, 5'd1}; fd_src = {5'd2, 5'd1};
        #1;
        tests_run++;
        if ({fwd_sel, stall} !== 5'd0) begin tests_failed++; $display("FAIL zero_rd_nonzero_src: fwd/stall got %b/%b want 0000/0", fwd_sel, stall); end
        set_idle();
    endtask

    task automatic test_saturate();
        apply_reset();
        dx_rd = 5'd5; dx_we = 1'b1; fd_src = {5'd0, 5'd5};
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (i == 65534) begin
                tests_run++;
                if (stall_cnt !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_pre: got %h want fffe", stall_cnt); end
            end
        end
        tests_run++;
        if (stall_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_multdiv();
        test_back_to_back();
        test_reset_mid();
        test_zero_reg();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning the register address width.
REQ-002 The block SHALL have parameter NSRC, default 2, meaning the number of source operands per instruction.
REQ-003 The block SHALL have parameter MD_LAT, default 32, meaning the multdiv latency in cycles (legal range 2..255).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have port fd_src, input, NSRC*REG_AW, the decode-stage source registers; operand k occupies bits [k*REG_AW +: REG_AW].
REQ-007 The block SHALL have port dx_src, input, NSRC*REG_AW, the execute-stage source registers, packed as fd_src.
REQ-008 The block SHALL have ports dx_rd (REG_AW), dx_we (1), dx_is_load (1) and dx_is_md (1), all inputs, giving the execute-stage destination, write enable, load flag and multdiv-start flag.
REQ-009 The block SHALL have ports xm_rd (REG_AW), xm_we (1) and xm_is_load (1), all inputs, giving the memory-stage destination, write enable and load flag.
REQ-010 The block SHALL have ports mw_rd (REG_AW) and mw_we (1), both inputs, giving the writeback-stage destination and write enable.
REQ-011 The block SHALL have port fwd_sel, output, 2*NSRC, the per-operand ALU input select: 00 regfile, 01 XM result, 10 MW result.
REQ-012 The block SHALL have port fd_fwd_sel, output, 2*NSRC, the per-operand decode/branch-compare select with the same encoding as fwd_sel.
REQ-013 The block SHALL have port stall, output, 1: when high, PC and F/D are held and a bubble is injected into D/X.
REQ-014 The block SHALL have ports md_busy (1), md_rd (REG_AW) and md_done (1), all outputs, giving the multdiv scoreboard state.
REQ-015 The block SHALL have port stall_cnt, output, 16, the saturating count of stall cycles.

Function
REQ-016 An instruction in stage S SHALL be a producer for register r when S_we=1, S_rd=r and r!=0; register 0 SHALL never be forwarded or cause a stall.
REQ-017 fwd_sel[k] SHALL be 01 if XM is a producer for dx_src[k] and xm_is_load=0, else 10 if MW is a producer for it, else 00; XM SHALL take priority over MW.
REQ-018 fd_fwd_sel[k] SHALL follow the same rule as fwd_sel[k], applied to fd_src[k]; a DX producer SHALL be covered by stall, not by forwarding.
REQ-019 stall SHALL be high combinationally when any of the following holds: (a) load-use: dx_is_load=1 and DX is a producer for any fd_src[k]; (b) branch-use: DX is a producer for any fd_src[k] and dx_is_load=0; (c) scoreboard: md_busy=1 and md_rd!=0 and md_rd equals any fd_src[k]; (d) structural: md_busy=1 and dx_is_md=1.
REQ-020 A multdiv SHALL be accepted when dx_is_md=1, md_busy=0 and stall=0. On acceptance, at the next edge: count loads MD_LAT-1, md_rd latches dx_rd (or 0 when dx_we=0), and md_busy goes to 1.
REQ-021 While md_busy=1, the count SHALL decrement by 1 on every edge, regardless of stall.
REQ-022 At the edge where count=0 and md_busy=1, md_busy SHALL go to 0 and md_done SHALL go high for exactly one cycle; md_rd SHALL hold its value until the next acceptance.
REQ-023 The states SHALL be IDLE (md_busy=0) and BUSY; the only transitions SHALL be IDLE->BUSY on acceptance and BUSY->IDLE at count 0. A start arriving in the final BUSY cycle SHALL be stalled and accepted in the following IDLE cycle.
REQ-024 stall_cnt SHALL increment on every edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-025 All outputs other than md_busy, md_rd, md_done and stall_cnt SHALL be purely combinational from the inputs and the registered state.

Reset
REQ-026 reset=0 SHALL asynchronously clear count, md_busy, md_rd, md_done and stall_cnt to 0, including when asserted mid-multdiv, in which case no md_done SHALL be produced.
REQ-027 During reset, stall SHALL depend only on the load-use and branch-use terms.

Configuration
REQ-028 With macro HAZARD_DECODE_FWD_EN defined, fd_fwd_sel SHALL behave per REQ-018 and REQ-019(b) SHALL be active.
REQ-029 Without HAZARD_DECODE_FWD_EN, fd_fwd_sel SHALL be tied to 0 and stall SHALL additionally assert when XM or MW is a producer for any fd_src[k]; REQ-019(b) still SHALL apply.

Verification
REQ-030 The bench SHALL cover: dx_src[0]=3, xm_rd=3 with xm_we=1, and mw_rd=3 with mw_we=1 -> fwd_sel[1:0]=01; then with xm_we=0 -> fwd_sel[1:0]=10.
REQ-031 The bench SHALL cover: dx_is_load=1, dx_rd=5, dx_we=1, fd_src[1]=5 -> stall=1 for exactly that cycle and stall_cnt increments by 1.
REQ-032 The bench SHALL cover: MD_LAT=4, multdiv accepted with dx_rd=7 -> md_busy high for 4 cycles, md_done pulses once, and fd_src[0]=7 stalls during all 4 busy cycles.
REQ-033 The bench SHALL cover: a second dx_is_md while busy -> stall held until IDLE, then accepted, with md_busy re-asserting the next cycle.
REQ-034 The bench SHALL cover: reset asserted at busy count 2 -> md_busy=0 and stall_cnt=0 immediately, and no md_done pulse.
REQ-035 The bench SHALL cover: all rd=0 with we=1 -> fwd_sel=0, fd_fwd_sel=0 and stall=0; and stall forced for 70000 cycles -> stall_cnt=16'hFFFF.
